// File: rtl/blackjack_round_ctrl.sv
// Round sequencer for the lab4 blackjack game: deals the opening hands through a
// request/valid card source, runs the player and dealer turns, resolves and tallies.
module blackjack_round_ctrl (
    input  logic        clk_200Hz,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        stay,
    output logic        card_req,
    input  logic        card_vld,
    input  logic [3:0]  card_idx,
    output logic [4:0]  player_total,
    output logic [4:0]  dealer_total,
    output logic [3:0]  card_out,
    output logic [1:0]  result,
    output logic        round_done,
    output logic [15:0] wins,
    output logic [15:0] losses,
    output logic [15:0] pushes,
    output logic [3:0]  state_dbg
);

    // Handshake: a card transfers on a rising edge where card_req && card_vld are both
    // high; card_req is a registered Moore output of the draw states, card_vld is free.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        PLAYER  = 4'd5,
        P_DRAW  = 4'd6,
        DEALER  = 4'd7,
        D_DRAW  = 4'd8,
        RESOLVE = 4'd9,
        DONE    = 4'd10
    } state_t;

    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSS = 2'b10;
    localparam logic [1:0] RES_PUSH = 2'b11;

    state_t      state;
    state_t      next_state;
    logic [2:0]  player_aces;
    logic [2:0]  dealer_aces;
    logic        accept;
    logic [7:0]  player_next;
    logic [7:0]  dealer_next;

    // Returns {ace_count, total}; one ace is softened from 11 to 1 when the hand busts.
    function automatic logic [7:0] add_card(input logic [4:0] total,
                                            input logic [2:0] aces,
                                            input logic [3:0] idx);
        logic [5:0] value;
        logic [5:0] sum;
        logic [2:0] count;
        if (idx == 4'd0)
            value = 6'd11;
        else if (idx <= 4'd9)
            value = {2'b00, idx} + 6'd1;
        else
            value = 6'd10;
        sum   = {1'b0, total} + value;
        count = aces + {2'b00, (idx == 4'd0)};
        if (sum > 6'd21 && count != 3'd0) begin
            sum   = sum - 6'd10;
            count = count - 3'd1;
        end
        return {count, sum[4:0]};
    endfunction

    function automatic logic is_draw(input state_t s);
        return (s == DEAL_P1) || (s == DEAL_D1) || (s == DEAL_P2) ||
               (s == DEAL_D2) || (s == P_DRAW)  || (s == D_DRAW);
    endfunction

    assign accept      = card_req && card_vld;
    assign player_next = add_card(player_total, player_aces, card_idx);
    assign dealer_next = add_card(dealer_total, dealer_aces, card_idx);
    assign state_dbg   = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start)  next_state = DEAL_P1;
            DEAL_P1:    if (accept) next_state = DEAL_D1;
            DEAL_D1:    if (accept) next_state = DEAL_P2;
            DEAL_P2:    if (accept) next_state = DEAL_D2;
            DEAL_D2:    if (accept) next_state = PLAYER;
            PLAYER: begin
                if (player_total == 5'd21) next_state = DEALER;
                else if (stay)             next_state = DEALER;
                else if (hit)              next_state = P_DRAW;
            end
            P_DRAW:  if (accept) next_state = (player_next[4:0] > 5'd21) ? RESOLVE : PLAYER;
            DEALER:  next_state = (dealer_total >= 5'd17) ? RESOLVE : D_DRAW;
            D_DRAW:  if (accept) next_state = DEALER;
            RESOLVE: next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_200Hz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            card_req     <= 1'b0;
            round_done   <= 1'b0;
            player_total <= 5'd0;
            dealer_total <= 5'd0;
            player_aces  <= 3'd0;
            dealer_aces  <= 3'd0;
            card_out     <= 4'd0;
            result       <= 2'b00;
            wins         <= 16'd0;
            losses       <= 16'd0;
            pushes       <= 16'd0;
        end else begin
            state      <= next_state;
            card_req   <= is_draw(next_state);
            round_done <= (state == RESOLVE);

            if ((state == IDLE || state == DONE) && start) begin
                player_total <= 5'd0;
                dealer_total <= 5'd0;
                player_aces  <= 3'd0;
                dealer_aces  <= 3'd0;
                card_out     <= 4'd0;
                result       <= 2'b00;
            end

            if (accept) begin
                card_out <= card_idx;
                case (state)
                    DEAL_P1, DEAL_P2, P_DRAW: begin
                        player_total <= player_next[4:0];
                        player_aces  <= player_next[7:5];
                    end
                    DEAL_D1, DEAL_D2, D_DRAW: begin
                        dealer_total <= dealer_next[4:0];
                        dealer_aces  <= dealer_next[7:5];
                    end
                    default: ;
                endcase
            end

            if (state == RESOLVE) begin
                if (player_total > 5'd21 || (dealer_total <= 5'd21 && player_total < dealer_total)) begin
                    result <= RES_LOSS;
                    if (losses != 16'hFFFF) losses <= losses + 16'd1;
                end else if (dealer_total > 5'd21 || player_total > dealer_total) begin
                    result <= RES_WIN;
                    if (wins != 16'hFFFF) wins <= wins + 16'd1;
                end else begin
                    result <= RES_PUSH;
                    if (pushes != 16'hFFFF) pushes <= pushes + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Bench for blackjack_round_ctrl: scripted rounds from a queued card source, with
// expected round outcomes held in a scoreboard queue and checked on round_done.
module tb_blackjack_round_ctrl;

    logic        clk_200Hz = 1'b0;
    logic        rst;
    logic        start;
    logic        hit;
    logic        stay;
    logic        card_req;
    logic        card_vld;
    logic [3:0]  card_idx;
    logic [4:0]  player_total;
    logic [4:0]  dealer_total;
    logic [3:0]  card_out;
    logic [1:0]  result;
    logic        round_done;
    logic [15:0] wins;
    logic [15:0] losses;
    logic [15:0] pushes;
    logic [3:0]  state_dbg;

    blackjack_round_ctrl dut (
        .clk_200Hz    (clk_200Hz),
        .rst          (rst),
        .start        (start),
        .hit          (hit),
        .stay         (stay),
        .card_req     (card_req),
        .card_vld     (card_vld),
        .card_idx     (card_idx),
        .player_total (player_total),
        .dealer_total (dealer_total),
        .card_out     (card_out),
        .result       (result),
        .round_done   (round_done),
        .wins         (wins),
        .losses       (losses),
        .pushes       (pushes),
        .state_dbg    (state_dbg)
    );

    always #5 clk_200Hz = ~clk_200Hz;

    localparam int ST_IDLE    = 0;
    localparam int ST_DEAL_P1 = 1;
    localparam int ST_PLAYER  = 5;
    localparam int ST_P_DRAW  = 6;
    localparam int ST_DEALER  = 7;
    localparam int ST_D_DRAW  = 8;
    localparam int ST_DONE    = 10;

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [11:0] exp_q[$];
    logic [3:0]  card_q[$];
    int          stall;
    logic        acc_prev;
    int          exp_wins;
    int          exp_losses;
    int          exp_pushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Advance to the next falling edge and run the card source for the coming edge.
    task automatic tick();
        @(negedge clk_200Hz);
        if (acc_prev && card_q.size() > 0) void'(card_q.pop_front());
        if (stall > 0 && card_req) begin
            stall--;
            card_vld = 1'b0;
        end else begin
            card_vld = (card_q.size() > 0);
        end
        card_idx = (card_q.size() > 0) ? card_q[0] : 4'd0;
        acc_prev = card_req && card_vld;
    endtask

    task automatic expect_round(input logic [1:0] res, input logic [4:0] p, input logic [4:0] d);
        exp_q.push_back({res, p, d});
    endtask

    task automatic start_round(input logic [3:0] c0, input logic [3:0] c1,
                               input logic [3:0] c2, input logic [3:0] c3,
                               input logic has_x, input logic [3:0] x,
                               input logic [4:0] init_p, input logic [4:0] init_d);
        card_q.push_back(c0);
        card_q.push_back(c1);
        card_q.push_back(c2);
        card_q.push_back(c3);
        if (has_x) card_q.push_back(x);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", state_dbg, ST_DEAL_P1);
        check("start_ptot", player_total, 0);
        check("start_dtot", dealer_total, 0);
        check("start_card_out", card_out, 0);
        check("start_result", result, 0);
        check("done_pulse_width", round_done, 0);
        for (int i = 0; i < 4; i++) begin
            check("deal_req", card_req, 1);
            tick();
        end
        check("player_state", state_dbg, ST_PLAYER);
        check("deal_ptot", player_total, init_p);
        check("deal_dtot", dealer_total, init_d);
    endtask

    task automatic wait_done(input string tag);
        logic [11:0] e;
        int n;
        n = 0;
        while (round_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL %s: round_done timeout got=0 want=1", tag);
        end else if (exp_q.size() == 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL %s: unexpected round_done got=1 want=0", tag);
        end else begin
            e = exp_q.pop_front();
            case (e[11:10])
                2'b01:   exp_wins++;
                2'b10:   exp_losses++;
                default: exp_pushes++;
            endcase
            check({tag, "_result"}, result, e[11:10]);
            check({tag, "_ptot"}, player_total, e[9:5]);
            check({tag, "_dtot"}, dealer_total, e[4:0]);
            check({tag, "_state"}, state_dbg, ST_DONE);
            check({tag, "_req"}, card_req, 0);
            check({tag, "_wins"}, wins, exp_wins);
            check({tag, "_losses"}, losses, exp_losses);
            check({tag, "_pushes"}, pushes, exp_pushes);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        hit        = 1'b0;
        stay       = 1'b0;
        card_vld   = 1'b0;
        card_idx   = 4'd0;
        stall      = 0;
        acc_prev   = 1'b0;
        exp_wins   = 0;
        exp_losses = 0;
        exp_pushes = 0;

        tick();
        tick();
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_req", card_req, 0);
        check("rst_ptot", player_total, 0);
        check("rst_dtot", dealer_total, 0);
        check("rst_result", result, 0);
        check("rst_done", round_done, 0);
        check("rst_wins", wins, 0);
        check("rst_losses", losses, 0);
        check("rst_pushes", pushes, 0);
        rst = 1'b0;
        tick();

        // hit/stay in IDLE are dropped
        hit  = 1'b1;
        stay = 1'b1;
        tick();
        hit  = 1'b0;
        stay = 1'b0;
        check("idle_pulse_state", state_dbg, ST_IDLE);
        tick();
        check("idle_pulse_req", card_req, 0);

        // natural 21 auto-stands, dealer draws to 17
        expect_round(2'b01, 5'd21, 5'd17);
        start_round(4'd9, 4'd5, 4'd0, 4'd6, 1'b1, 4'd3, 5'd21, 5'd13);
        wait_done("r1");

        // player busts on a hit; start issued in the round_done cycle
        expect_round(2'b10, 5'd27, 5'd20);
        start_round(4'd8, 4'd9, 4'd7, 4'd9, 1'b1, 4'd9, 5'd17, 5'd20);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("r2_pdraw", state_dbg, ST_P_DRAW);
        wait_done("r2");
        check("r2_no_extra_draw", card_q.size(), 0);

        // two aces, one softened; hit to 21 auto-stands
        expect_round(2'b01, 5'd21, 5'd17);
        start_round(4'd0, 4'd9, 4'd0, 4'd6, 1'b1, 4'd8, 5'd12, 5'd17);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        wait_done("r3");

        // hit and stay together: stay wins, push at 20
        expect_round(2'b11, 5'd20, 5'd20);
        start_round(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 4'd0, 5'd20, 5'd20);
        hit  = 1'b1;
        stay = 1'b1;
        tick();
        hit  = 1'b0;
        stay = 1'b0;
        check("r4_dealer", state_dbg, ST_DEALER);
        wait_done("r4");
        check("r4_card_unused", card_q.size(), 1);
        card_q.delete();

        // start ignored in PLAYER; dealer draw stalled three cycles, dealer busts
        expect_round(2'b01, 5'd19, 5'd26);
        start_round(4'd9, 4'd5, 4'd8, 4'd9, 1'b1, 4'd9, 5'd19, 5'd16);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r5_start_ignored", state_dbg, ST_PLAYER);
        stall = 3;
        stay  = 1'b1;
        tick();
        stay  = 1'b0;
        check("r5_dealer", state_dbg, ST_DEALER);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r5_wait_req", card_req, 1);
            check("r5_wait_state", state_dbg, ST_D_DRAW);
            check("r5_wait_dtot", dealer_total, 16);
        end
        wait_done("r5");

        // asynchronous reset in the middle of a player draw
        start_round(4'd8, 4'd9, 4'd7, 4'd9, 1'b0, 4'd0, 5'd17, 5'd20);
        stall = 50;
        hit   = 1'b1;
        tick();
        hit   = 1'b0;
        check("r6_pdraw", state_dbg, ST_P_DRAW);
        check("r6_req_high", card_req, 1);
        rst = 1'b1;
        #1;
        check("r6_rst_req", card_req, 0);
        check("r6_rst_ptot", player_total, 0);
        check("r6_rst_dtot", dealer_total, 0);
        check("r6_rst_wins", wins, 0);
        check("r6_rst_losses", losses, 0);
        check("r6_rst_state", state_dbg, ST_IDLE);
        tick();
        rst = 1'b0;
        card_q.delete();
        stall      = 0;
        acc_prev   = 1'b0;
        exp_wins   = 0;
        exp_losses = 0;
        exp_pushes = 0;
        tick();

        // tallies restart from zero after reset
        expect_round(2'b11, 5'd20, 5'd20);
        start_round(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 5'd20, 5'd20);
        stay = 1'b1;
        tick();
        stay = 1'b0;
        wait_done("r7");
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
